// File: rtl/instr_register_calc_if.sv
// Bus between the instruction register file and its driver.
// The master side issues writes and reads; the slave side returns read data and status.
interface instr_register_calc_if #(
   parameter int DEPTH = 32,
   parameter int OP_W  = 32
);
   localparam int AW = $clog2(DEPTH);

   logic              load_en;
   logic [AW-1:0]     write_pointer;
   logic [2:0]        opcode;
   logic [OP_W-1:0]   operand_a;
   logic [OP_W-1:0]   operand_b;
   logic [AW-1:0]     read_pointer;
   logic              rd_req;
   logic              rd_valid;
   logic [2:0]        rd_opc;
   logic [OP_W-1:0]   rd_op_a;
   logic [OP_W-1:0]   rd_op_b;
   logic [2*OP_W-1:0] rd_result;
   logic              rd_entry_valid;
   logic              rd_err;
   logic [AW:0]       wr_count;
   logic [AW-1:0]     auto_ptr;

   modport master (
      output load_en, write_pointer, opcode, operand_a, operand_b, read_pointer, rd_req,
      input  rd_valid, rd_opc, rd_op_a, rd_op_b, rd_result, rd_entry_valid, rd_err,
             wr_count, auto_ptr
   );

   modport slave (
      input  load_en, write_pointer, opcode, operand_a, operand_b, read_pointer, rd_req,
      output rd_valid, rd_opc, rd_op_a, rd_op_b, rd_result, rd_entry_valid, rd_err,
             wr_count, auto_ptr
   );
endinterface

// File: rtl/instr_register_calc.sv
// Instruction register file that evaluates each instruction when it is written.
// Writes go through a two-stage pipeline: capture, then ALU and array update. Reads have one cycle of latency.
module instr_register_calc #(
   parameter int DEPTH    = 32,
   parameter int OP_W     = 32,
   parameter bit AUTO_INC = 1'b0,
   parameter int AW       = $clog2(DEPTH)
) (
   input logic                 clk,
   input logic                 reset_n,
   instr_register_calc_if.slave bus
);
   typedef enum logic [2:0] {
      ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
   } opcode_t;

   typedef struct packed {
      logic              valid;
      logic              err;
      logic [2:0]        opc;
      logic [OP_W-1:0]   op_a;
      logic [OP_W-1:0]   op_b;
      logic [2*OP_W-1:0] result;
   } entry_t;

   // DEPTH is a power of two, so the full count is just the top bit.
   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   logic            s1_valid_q, s1_valid_d;
   logic [AW-1:0]   s1_addr_q, s1_addr_d;
   logic [2:0]      s1_opc_q, s1_opc_d;
   logic [OP_W-1:0] s1_a_q, s1_a_d;
   logic [OP_W-1:0] s1_b_q, s1_b_d;
   logic [AW-1:0]   auto_ptr_q, auto_ptr_d;
   logic [AW:0]     wr_count_q, wr_count_d;
   logic            rd_valid_q, rd_valid_d;
   entry_t          rd_entry_q, rd_entry_d;
   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];

   logic signed [2*OP_W-1:0] a_ext, b_ext, alu_res;
   logic                     alu_err;

   always_comb begin
      a_ext   = {{OP_W{s1_a_q[OP_W-1]}}, s1_a_q};
      b_ext   = {{OP_W{s1_b_q[OP_W-1]}}, s1_b_q};
      alu_res = '0;
      alu_err = 1'b0;
      case (opcode_t'(s1_opc_q))
         ZERO:  alu_res = '0;
         PASSA: alu_res = a_ext;
         PASSB: alu_res = b_ext;
         ADD:   alu_res = a_ext + b_ext;
         SUB:   alu_res = a_ext - b_ext;
         MULT:  alu_res = a_ext * b_ext;
         // Operands are widened first, so most-negative / -1 cannot overflow.
         DIV: begin
            if (s1_b_q == '0) alu_err = 1'b1;
            else              alu_res = a_ext / b_ext;
         end
         MOD: begin
            if (s1_b_q == '0) alu_err = 1'b1;
            else              alu_res = a_ext % b_ext;
         end
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      s1_valid_d = bus.load_en;
      s1_addr_d  = s1_addr_q;
      s1_opc_d   = s1_opc_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      auto_ptr_d = auto_ptr_q;
      if (bus.load_en) begin
         s1_addr_d = AUTO_INC ? auto_ptr_q : bus.write_pointer;
         s1_opc_d  = bus.opcode;
         s1_a_d    = bus.operand_a;
         s1_b_d    = bus.operand_b;
         if (AUTO_INC) auto_ptr_d = auto_ptr_q + 1'b1;
      end

      mem_d      = mem_q;
      wr_count_d = wr_count_q;
      if (s1_valid_q) begin
         mem_d[s1_addr_q] = '{valid: 1'b1, err: alu_err, opc: s1_opc_q,
                              op_a: s1_a_q, op_b: s1_b_q, result: alu_res};
         if (!mem_q[s1_addr_q].valid && wr_count_q != FULL_CNT)
            wr_count_d = wr_count_q + 1'b1;
      end

      // The read sees mem_q, so a same-edge S2 write is not forwarded.
      rd_valid_d = bus.rd_req;
      rd_entry_d = bus.rd_req ? mem_q[bus.read_pointer] : rd_entry_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s1_opc_q   <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         auto_ptr_q <= '0;
         wr_count_q <= '0;
         rd_valid_q <= 1'b0;
         rd_entry_q <= '0;
         mem_q      <= '{default: '0};
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
         s1_opc_q   <= s1_opc_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         auto_ptr_q <= auto_ptr_d;
         wr_count_q <= wr_count_d;
         rd_valid_q <= rd_valid_d;
         rd_entry_q <= rd_entry_d;
         mem_q      <= mem_d;
      end
   end

   assign bus.rd_valid       = rd_valid_q;
   assign bus.rd_opc         = rd_entry_q.opc;
   assign bus.rd_op_a        = rd_entry_q.op_a;
   assign bus.rd_op_b        = rd_entry_q.op_b;
   assign bus.rd_result      = rd_entry_q.result;
   assign bus.rd_entry_valid = rd_entry_q.valid;
   assign bus.rd_err         = rd_entry_q.err;
   assign bus.wr_count       = wr_count_q;
   assign bus.auto_ptr       = auto_ptr_q;
endmodule

// File: tb/tb_instr_register_calc.sv
// Directed bench for instr_register_calc: an addressed instance (DEPTH=32) and an auto-increment instance (DEPTH=4).
module tb_instr_register_calc;
   localparam logic [2:0] OP_ZERO = 3'd0, OP_PASSA = 3'd1, OP_PASSB = 3'd2, OP_ADD = 3'd3,
                          OP_SUB = 3'd4, OP_MULT = 3'd5, OP_DIV = 3'd6, OP_MOD = 3'd7;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   instr_register_calc_if #(.DEPTH(32), .OP_W(32)) bus0 ();
   instr_register_calc_if #(.DEPTH(4),  .OP_W(32)) bus1 ();

   instr_register_calc #(.DEPTH(32), .OP_W(32), .AUTO_INC(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0)
   );
   instr_register_calc #(.DEPTH(4), .OP_W(32), .AUTO_INC(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1)
   );

   typedef struct {
      logic [2:0]  opc;
      logic [31:0] a;
      logic [31:0] b;
      int          addr;
      logic [63:0] res;
      logic        err;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic write0(input int addr, input logic [2:0] opc, input logic [31:0] a,
                         input logic [31:0] b);
      bus0.write_pointer = addr[4:0];
      bus0.opcode        = opc;
      bus0.operand_a     = a;
      bus0.operand_b     = b;
      bus0.load_en       = 1'b1;
      @(negedge clk);
      bus0.load_en       = 1'b0;
      $display("[TB] dut0 write addr=%0d opc=%0d a=%h b=%h", addr, opc, a, b);
   endtask

   task automatic read0(input int addr);
      bus0.read_pointer = addr[4:0];
      bus0.rd_req       = 1'b1;
      @(negedge clk);
      bus0.rd_req       = 1'b0;
      $display("[TB] dut0 read addr=%0d valid=%0b ev=%0b opc=%0d a=%h res=%h err=%0b",
               addr, bus0.rd_valid, bus0.rd_entry_valid, bus0.rd_opc, bus0.rd_op_a,
               bus0.rd_result, bus0.rd_err);
   endtask

   task automatic write1(input int ptr, input logic [31:0] a);
      bus1.write_pointer = ptr[1:0];
      bus1.opcode        = OP_PASSA;
      bus1.operand_a     = a;
      bus1.operand_b     = '0;
      bus1.load_en       = 1'b1;
      @(negedge clk);
      bus1.load_en       = 1'b0;
      $display("[TB] dut1 write ptr=%0d a=%h", ptr, a);
   endtask

   task automatic read1(input int addr);
      bus1.read_pointer = addr[1:0];
      bus1.rd_req       = 1'b1;
      @(negedge clk);
      bus1.rd_req       = 1'b0;
      $display("[TB] dut1 read addr=%0d valid=%0b ev=%0b a=%h", addr, bus1.rd_valid,
               bus1.rd_entry_valid, bus1.rd_op_a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected $finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{OP_ADD,   -32'sd15,     32'sd7,       0,  -64'sd8,                1'b0};
      vecs[1]  = '{OP_MULT,  32'h7FFFFFFF, 32'd2,        1,  64'h00000000FFFFFFFE,   1'b0};
      vecs[2]  = '{OP_MOD,   -32'sd7,      32'sd3,       2,  -64'sd1,                1'b0};
      vecs[3]  = '{OP_DIV,   32'd10,       32'd0,        5,  64'd0,                  1'b1};
      vecs[4]  = '{OP_DIV,   -32'sd7,      32'sd2,       4,  -64'sd3,                1'b0};
      vecs[5]  = '{OP_SUB,   32'sd5,       -32'sd3,      6,  64'sd8,                 1'b0};
      vecs[6]  = '{OP_PASSB, 32'd0,        -32'sd2,      8,  -64'sd2,                1'b0};
      vecs[7]  = '{OP_ZERO,  32'd123,      32'd456,      9,  64'd0,                  1'b0};
      vecs[8]  = '{OP_MOD,   32'sd7,       -32'sd3,      10, 64'sd1,                 1'b0};
      vecs[9]  = '{OP_MULT,  -32'sd3,      32'sd4,       11, -64'sd12,               1'b0};
      vecs[10] = '{OP_PASSA, -32'sd5,      32'sd9,       12, -64'sd5,                1'b0};
      vecs[11] = '{OP_MOD,   32'sd5,       32'd0,        13, 64'd0,                  1'b1};
      vecs[12] = '{OP_MULT,  32'h80000000, 32'h80000000, 15, 64'h4000000000000000,   1'b0};
      vecs[13] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 16, 64'h0000000080000000,   1'b0};

      bus0.load_en = 1'b0; bus0.write_pointer = '0; bus0.opcode = '0;
      bus0.operand_a = '0; bus0.operand_b = '0; bus0.read_pointer = '0; bus0.rd_req = 1'b0;
      bus1.load_en = 1'b0; bus1.write_pointer = '0; bus1.opcode = '0;
      bus1.operand_a = '0; bus1.operand_b = '0; bus1.read_pointer = '0; bus1.rd_req = 1'b0;

      // Power-on reset and empty array.
      repeat (2) @(negedge clk);
      chk("reset_wr_count", 64'(bus0.wr_count), 64'd0);
      chk("reset_rd_valid", 64'(bus0.rd_valid), 64'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         read0(i);
         chk("empty_rd_valid", 64'(bus0.rd_valid), 64'd1);
         chk("empty_entry_valid", 64'(bus0.rd_entry_valid), 64'd0);
         chk("empty_result", bus0.rd_result, 64'd0);
      end
      chk("empty_wr_count", 64'(bus0.wr_count), 64'd0);

      // ALU vectors, written back-to-back then read back-to-back.
      foreach (vecs[i]) write0(vecs[i].addr, vecs[i].opc, vecs[i].a, vecs[i].b);
      @(negedge clk);
      chk("vec_wr_count", 64'(bus0.wr_count), 64'd14);
      foreach (vecs[i]) begin
         read0(vecs[i].addr);
         chk("vec_rd_valid", 64'(bus0.rd_valid), 64'd1);
         chk("vec_entry_valid", 64'(bus0.rd_entry_valid), 64'd1);
         chk("vec_opc", 64'(bus0.rd_opc), 64'(vecs[i].opc));
         chk("vec_op_a", 64'(bus0.rd_op_a), 64'(vecs[i].a));
         chk("vec_op_b", 64'(bus0.rd_op_b), 64'(vecs[i].b));
         chk("vec_result", bus0.rd_result, vecs[i].res);
         chk("vec_err", 64'(bus0.rd_err), 64'(vecs[i].err));
      end

      // Write-to-read hazard on address 3: no forwarding, rewrite keeps the count.
      write0(3, OP_PASSA, 32'd4, 32'd0);
      @(negedge clk);
      write0(3, OP_PASSA, 32'd9, 32'd0);
      read0(3);
      chk("hazard_old_op_a", 64'(bus0.rd_op_a), 64'd4);
      read0(3);
      chk("hazard_new_op_a", 64'(bus0.rd_op_a), 64'd9);
      chk("hazard_wr_count", 64'(bus0.wr_count), 64'd15);

      // Consecutive writes to one address: the later one wins.
      write0(14, OP_PASSA, 32'd1, 32'd0);
      write0(14, OP_PASSA, 32'd2, 32'd0);
      @(negedge clk);
      read0(14);
      chk("same_addr_op_a", 64'(bus0.rd_op_a), 64'd2);
      chk("same_addr_wr_count", 64'(bus0.wr_count), 64'd16);
      @(negedge clk);
      chk("idle_rd_valid", 64'(bus0.rd_valid), 64'd0);
      chk("idle_hold_op_a", 64'(bus0.rd_op_a), 64'd2);

      // Auto-increment wrap on the DEPTH=4 instance.
      for (int i = 1; i <= 5; i++) write1(3, 32'(i));
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         read1(i);
         chk("auto_entry_valid", 64'(bus1.rd_entry_valid), 64'd1);
         chk("auto_op_a", 64'(bus1.rd_op_a), (i == 0) ? 64'd5 : 64'(i + 1));
      end
      chk("auto_ptr", 64'(bus1.auto_ptr), 64'd1);
      chk("auto_wr_count", 64'(bus1.wr_count), 64'd4);
      chk("no_auto_ptr", 64'(bus0.auto_ptr), 64'd0);

      // Reset asserted right after a write to address 7 is captured.
      read0(0);
      chk("pre_reset_result", bus0.rd_result, -64'sd8);
      bus0.write_pointer = 5'd7;
      bus0.opcode        = OP_PASSA;
      bus0.operand_a     = 32'd77;
      bus0.load_en       = 1'b1;
      @(posedge clk);
      #1;
      reset_n      = 1'b0;
      bus0.load_en = 1'b0;
      #1;
      chk("rst_rd_result", bus0.rd_result, 64'd0);
      chk("rst_rd_opc", 64'(bus0.rd_opc), 64'd0);
      chk("rst_rd_op_a", 64'(bus0.rd_op_a), 64'd0);
      chk("rst_rd_valid", 64'(bus0.rd_valid), 64'd0);
      chk("rst_entry_valid", 64'(bus0.rd_entry_valid), 64'd0);
      chk("rst_wr_count", 64'(bus0.wr_count), 64'd0);
      chk("rst_auto_ptr", 64'(bus1.auto_ptr), 64'd0);
      chk("rst_auto_wr_count", 64'(bus1.wr_count), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      read0(7);
      chk("post_rst_rd_valid", 64'(bus0.rd_valid), 64'd1);
      chk("post_rst_entry7_valid", 64'(bus0.rd_entry_valid), 64'd0);
      chk("post_rst_entry7_op_a", 64'(bus0.rd_op_a), 64'd0);
      read0(0);
      chk("post_rst_entry0_result", bus0.rd_result, 64'd0);
      chk("post_rst_wr_count", 64'(bus0.wr_count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
